// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   MEM-stage data-memory unit for the 5-stage MIPS pipeline. It owns a
//   word-organised, little-endian data memory and performs byte, half and
//   word loads and stores with a configurable access latency. While an
//   access is in flight it stalls the upstream pipeline.
//
// Optional build macro:
//   MISALIGN_CHECK_EN - when defined, misaligned half/word accesses are
//                       flagged and suppressed (no array access) and take a
//                       one-cycle stall; when undefined the low address bits
//                       are forced to alignment and the access proceeds.
//
// Parameters:
//   DEPTH    number of 32-bit words in data memory (power of 2, >= 4)
//   LATENCY  cycles from request acceptance to array access (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   iMemRead     load request from EX/MEM
//   iMemWrite    store request from EX/MEM (wins when both requests high)
//   iSize        00 byte, 01 half, 10/11 word
//   iUnsigned    loads: 1 zero-extend, 0 sign-extend
//   iAddr        byte address
//   iWriteData   store data (byte/half from low bits)
//   oMemRes      registered load result, to MEM/WB
//   oStall       pipeline hold while high
//   oMisaligned  misaligned-access flag, high for the DONE cycle only
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [1:0]  iSize,
  input  logic        iUnsigned,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWriteData,
  output logic [31:0] oMemRes,
  output logic        oStall,
  output logic        oMisaligned
);

  localparam int AW = $clog2(DEPTH);
  // The counter only ever holds LATENCY-1 down to 0.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_write;
  logic [31:0]     r_mem_res;
  logic            r_misaligned;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_mis;
  logic [AW+1:0]   w_addr_forced;
  logic            w_access;
  logic            w_do_write;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load_val;
  logic [3:0]      w_be;
  logic [31:0]     w_wrep;
  logic            w_unused_addr;

  // Upper address bits are ignored so addresses wrap modulo DEPTH*4.
  assign w_unused_addr = ^iAddr[31:AW+2];

  assign w_req      = iMemRead | iMemWrite;
  assign w_access   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_do_write = w_access && r_write && !rst;
  assign w_idx      = r_addr[AW+1:2];
  assign w_word     = r_mem[w_idx];

  // Misalignment detection on the incoming request.
  always_comb begin
`ifdef MISALIGN_CHECK_EN
    case (iSize)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = iAddr[0];
      default: w_mis = (iAddr[1:0] != 2'b00);
    endcase
`else
    w_mis = 1'b0;
`endif
  end

  // Force the low address bits to natural alignment for half/word accesses.
  always_comb begin
    w_addr_forced = iAddr[AW+1:0];
    case (iSize)
      2'b00:   w_addr_forced[1:0] = iAddr[1:0];
      2'b01:   w_addr_forced[0]   = 1'b0;
      default: w_addr_forced[1:0] = 2'b00;
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    if (r_addr[1]) begin
      w_half = w_word[31:16];
    end else begin
      w_half = w_word[15:0];
    end
    case (r_size)
      2'b00:   w_load_val = r_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_val = r_uns ? {16'h0000, w_half}   : {{16{w_half[15]}}, w_half};
      default: w_load_val = w_word;
    endcase
  end

  // Store byte enables with the store data replicated across lanes.
  always_comb begin
    case (r_size)
      2'b00: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_wrep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wrep = r_wdata;
      end
    endcase
  end

  // Data array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_do_write && w_be[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  // Access sequencer: accept in IDLE, count out latency in WAIT, one DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= 32'h0000_0000;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_write      <= 1'b0;
      r_mem_res    <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= w_addr_forced;
            r_wdata <= iWriteData;
            r_size  <= iSize;
            r_uns   <= iUnsigned;
            r_write <= iMemWrite;
            if (w_mis) begin
              // Suppressed access: skip the array entirely.
              r_misaligned <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= S_WAIT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            if (!r_write) begin
              r_mem_res <= w_load_val;
            end else begin
              r_mem_res <= r_mem_res;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Requests still present here belong to the finishing access.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the very cycle a request appears, hence combinational.
  assign oStall      = (r_state == S_WAIT) || ((r_state == S_IDLE) && w_req);
  assign oMemRes     = r_mem_res;
  assign oMisaligned = r_misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//   Self-checking bench for mem_access_stage. A behavioural word-array model
//   predicts load results, stall length and the misaligned flag; directed
//   scenarios cover the documented cases and a random phase mixes sizes,
//   signedness, address wrap and read/write combinations.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iMemRead;
  logic        iMemWrite;
  logic [1:0]  iSize;
  logic        iUnsigned;
  logic [31:0] iAddr;
  logic [31:0] iWriteData;
  logic [31:0] oMemRes;
  logic        oStall;
  logic        oMisaligned;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_res;

  // Free-running clock.
  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .iMemRead   (iMemRead),
    .iMemWrite  (iMemWrite),
    .iSize      (iSize),
    .iUnsigned  (iUnsigned),
    .iAddr      (iAddr),
    .iWriteData (iWriteData),
    .oMemRes    (oMemRes),
    .oStall     (oStall),
    .oMisaligned(oMisaligned)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 32'd2) != 32'd0;
    return (a % 32'd4) != 32'd0;
  endfunction

  function automatic logic [31:0] load_ref(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] off;
    logic [31:0] v;
    w   = model[(a / 32'd4) % DEPTH];
    off = a % 32'd4;
    if (sz == 2'd0) begin
      v = (w >> (32'd8 * off)) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      off = off - (off % 32'd2);
      v = (w >> (32'd8 * off)) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void store_ref(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int unsigned idx;
    logic [31:0] off;
    logic [31:0] mask;
    idx = (a / 32'd4) % DEPTH;
    off = a % 32'd4;
    if (sz == 2'd0) begin
      mask = 32'h0000_00FF << (32'd8 * off);
      model[idx] = (model[idx] & ~mask) | ((d & 32'h0000_00FF) << (32'd8 * off));
    end else if (sz == 2'd1) begin
      off  = off - (off % 32'd2);
      mask = 32'h0000_FFFF << (32'd8 * off);
      model[idx] = (model[idx] & ~mask) | ((d & 32'h0000_FFFF) << (32'd8 * off));
    end else begin
      model[idx] = d;
    end
  endfunction

  // One complete transaction starting in an IDLE cycle; checks stall length,
  // DONE-cycle result and misaligned flag.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d, input string tag);
    int          n;
    int          exp_stall;
    logic [31:0] exp_res;
    logic        mis;
    @(negedge clk);
    iMemRead   = rd;
    iMemWrite  = wr;
    iSize      = sz;
    iUnsigned  = uns;
    iAddr      = a;
    iWriteData = d;
    #1;
    if (!rd && !wr) begin
      check_eq({tag, "_idle_stall"}, {31'd0, oStall}, 32'd0);
      check_eq({tag, "_idle_res"}, oMemRes, last_res);
      return;
    end
    mis       = MIS_EN && is_mis(sz, a);
    exp_stall = mis ? 1 : LAT + 1;
    if (mis) begin
      exp_res = last_res;
    end else if (wr) begin
      store_ref(sz, a, d);
      exp_res = last_res;
    end else begin
      exp_res = load_ref(sz, uns, a);
    end
    n = 0;
    while (oStall === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_stall_len"}, n, exp_stall);
    check_eq({tag, "_res"}, oMemRes, exp_res);
    check_eq({tag, "_mis"}, {31'd0, oMisaligned}, {31'd0, mis});
    last_res  = exp_res;
    iMemRead  = 1'b0;
    iMemWrite = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    rst        = 1'b1;
    iMemRead   = 1'b0;
    iMemWrite  = 1'b0;
    iSize      = 2'b00;
    iUnsigned  = 1'b0;
    iAddr      = 32'h0000_0000;
    iWriteData = 32'h0000_0000;
    last_res   = 32'h0000_0000;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_stall", {31'd0, oStall}, 32'd0);
    check_eq("rst_res", oMemRes, 32'h0000_0000);
    check_eq("rst_mis", {31'd0, oMisaligned}, 32'd0);
    rst = 1'b0;

    // Give every word a known value (zero).
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 32'h0000_0000;
      do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'(i * 4), 32'h0000_0000, "init");
    end

    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "st_w");
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld_w");
    check_eq("tp_deadbeef", oMemRes, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0055, "st_b");
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld_w2");
    check_eq("tp_dead55ef", oMemRes, 32'hDEAD_55EF);
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "ld_bs");
    check_eq("tp_byte_s", oMemRes, 32'hFFFF_FFDE);
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "ld_bu");
    check_eq("tp_byte_u", oMemRes, 32'h0000_00DE);
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "ld_hs");
    check_eq("tp_half_s", oMemRes, 32'hFFFF_DEAD);
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "ld_hu");
    check_eq("tp_half_u", oMemRes, 32'h0000_DEAD);
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10 + 32'(DEPTH * 4), 32'h0, "ld_wrap");
    check_eq("tp_wrap", oMemRes, 32'hDEAD_55EF);

    // Reset in the middle of a store: the store must be dropped.
    @(negedge clk);
    iMemWrite  = 1'b1;
    iSize      = 2'b10;
    iAddr      = 32'h20;
    iWriteData = 32'h1234_5678;
    @(negedge clk);
    rst       = 1'b1;
    iMemWrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_stall", {31'd0, oStall}, 32'd0);
    check_eq("midrst_res", oMemRes, 32'h0000_0000);
    last_res = 32'h0000_0000;
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "ld_after_rst");
    check_eq("tp_dropped_store", oMemRes, 32'h0000_0000);

    // Request held high across two accesses: one DONE gap each.
    @(negedge clk);
    iMemRead  = 1'b1;
    iSize     = 2'b10;
    iUnsigned = 1'b0;
    iAddr     = 32'h10;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("hold_stall_%0d", i), {31'd0, oStall},
               {31'd0, (i % (LAT + 2)) < (LAT + 1)});
      @(negedge clk);
    end
    iMemRead = 1'b0;
    last_res = load_ref(2'b10, 1'b0, 32'h10);
    check_eq("hold_res", oMemRes, last_res);

    // Misaligned accesses: suppressed with the check built in, forced aligned otherwise.
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, "mis_ld");
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFE_F00D, "mis_st");
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "mis_chk");
    check_eq("tp_mis_mem", oMemRes, MIS_EN ? 32'h0000_0000 : 32'hCAFE_F00D);
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, "mis_half");

    // Random mix of idle cycles, loads, stores and simultaneous requests.
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom & ~32'h0000_03FC) | (32'($urandom_range(0, 15)) << 2);
      do_access(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
